// File: rtl/hamming_pipe_encoder.sv
// Two-stage pipelined Hamming SEC encoder with valid/ready handshake and transfer counter.
// Optional macro HAMMING_SECDED_EN appends an overall even-parity bit (SECDED).
module hamming_pipe_encoder #(
  parameter int DATA_W = 16,
  parameter int PAR_W  = 5,
  parameter int CNT_W  = 16,
`ifdef HAMMING_SECDED_EN
  localparam int SEC_W = 1,
`else
  localparam int SEC_W = 0,
`endif
  localparam int CW_W  = DATA_W + PAR_W + SEC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CW_W-1:0]   out_code,
  output logic [CNT_W-1:0]  code_cnt
);

  localparam int N = DATA_W + PAR_W;

  if (DATA_W < 4 || DATA_W > 57) begin : g_bad_data_w
    $error("hamming_pipe_encoder: DATA_W must be within 4..57");
  end
  if ((1 << PAR_W) < N + 1) begin : g_bad_par_w
    $error("hamming_pipe_encoder: PAR_W too small for DATA_W");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("hamming_pipe_encoder: CNT_W must be at least 1");
  end

  // XOR of the indices of all set data positions gives every p_k at once;
  // both loops walk positions in ascending order, consuming bits by shifting.
  function automatic logic [N-1:0] sec_encode(input logic [DATA_W-1:0] m);
    logic [DATA_W-1:0] m_sh;
    logic [PAR_W-1:0]  syn;
    logic [PAR_W-1:0]  syn_sh;
    logic [N-1:0]      y;
    m_sh = m;
    syn  = '0;
    for (int pos = 1; pos <= N; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        syn  = syn ^ ({PAR_W{m_sh[0]}} & PAR_W'(pos));
        m_sh = m_sh >> 1;
      end
    end
    m_sh   = m;
    syn_sh = syn;
    y      = '0;
    for (int pos = 1; pos <= N; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        y    = {m_sh[0], y[N-1:1]};
        m_sh = m_sh >> 1;
      end else begin
        y      = {syn_sh[0], y[N-1:1]};
        syn_sh = syn_sh >> 1;
      end
    end
    return y;
  endfunction

  function automatic logic [CW_W-1:0] full_encode(input logic [DATA_W-1:0] m);
    logic [N-1:0] sec;
    sec = sec_encode(m);
`ifdef HAMMING_SECDED_EN
    return {^sec, sec};
`else
    return sec;
`endif
  endfunction

  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] s1_data_q,  s1_data_d;
  logic              s2_valid_q, s2_valid_d;
  logic [CW_W-1:0]   s2_code_q,  s2_code_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;
  logic              s1_adv;
  logic              s2_adv;
  logic              out_xfer;

  // Stage advance, handshake and next-state computation.
  always_comb begin
    s2_adv     = !s2_valid_q || out_ready;
    s1_adv     = !s1_valid_q || s2_adv;
    out_xfer   = s2_valid_q && out_ready;
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s2_valid_d = s2_valid_q;
    s2_code_d  = s2_code_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_data_d = in_data;
      end else begin
        s1_data_d = s1_data_q;
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_code_d = full_encode(s1_data_q);
      end else begin
        s2_code_d = s2_code_q;
      end
    end else begin
      s2_valid_d = s2_valid_q;
    end
    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, out_xfer};
  end

  // Pipeline and counter registers; reset discards anything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_code_q  <= '0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s2_valid_q <= s2_valid_d;
      s2_code_q  <= s2_code_d;
      cnt_q      <= cnt_d;
    end
  end

  assign in_ready  = s1_adv;
  assign out_valid = s2_valid_q;
  assign out_code  = s2_code_q;
  assign code_cnt  = cnt_q;

endmodule
